dmem_arbiter: RTL

- Shares the single-port data-memory block RAM between two requesters.
- Requester 1 is the CPU load/store path, i.e. the memory-side traffic of the memory/IO decoder. Requester 2 is the UART program/data loader.
- Sequences each access over the RAM's 1-cycle read latency.
- Stalls the CPU while the CPU's access is pending.
- Loader has priority; a starvation counter guarantees the CPU forward progress.

---
 rtl/dmem_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store path and the UART loader (loader priority, starvation-bounded).
// Latency: 3 cycles per access (IDLE grant, ISS, DONE); read data returned combinationally in DONE, then held.
// Backpressure: CPU is held via cpu_stall until its DONE cycle; loader holds ld_req until the one-cycle ld_ack.
// Optional: define DMEM_ARB_BOUND_EN to reject addresses above the RAM (no RAM access, zero read data, err pulse).

module dmem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    // CPU load/store port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    // UART loader port
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       ld_rdata,
    output logic              ld_ack,
    // block RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    // out-of-range indication
    output logic              err
);

    localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CPU_ISS  = 3'd1;
    localparam logic [2:0] CPU_DONE = 3'd2;
    localparam logic [2:0] LD_ISS   = 3'd3;
    localparam logic [2:0] LD_DONE  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  starve_cnt;

    logic              grant_ld;
    logic              grant_cpu;

    // request selected for the grant being made this cycle
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_oob;

    // access captured at grant; drives the RAM in ISS and steers data in DONE
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_oob;

    logic              in_iss;
    logic              cpu_done;
    logic              ld_done;
    logic [31:0]       rd_val;
    logic [31:0]       cpu_rdata_q;
    logic [31:0]       ld_rdata_q;

    // byte-lane bits are dropped (word access only); upper bits alias unless bounds checking is built in
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    assign in_iss   = (state == CPU_ISS) || (state == LD_ISS);
    assign cpu_done = (state == CPU_DONE);
    assign ld_done  = (state == LD_DONE);

    // Arbitrate in IDLE: loader wins unless the CPU has been passed over STARVE_MAX times in a row
    always_comb begin
        grant_ld  = 1'b0;
        grant_cpu = 1'b0;
        if (state == IDLE) begin
            grant_ld  = ld_req && (!cpu_req || (starve_cnt != STARVE_LIM));
            grant_cpu = cpu_req && !grant_ld;
        end
    end

    // Select the winning requester's access fields
    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (grant_ld) begin
            sel_we    = ld_we;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
        end
    end

`ifdef DMEM_ARB_BOUND_EN
    // Any address bit above the RAM's word range marks the access out of range
    always_comb begin
        sel_oob = |sel_addr[31:ADDR_W+2];
    end
`else
    // Without bounds checking upper bits are ignored and addresses alias
    always_comb begin
        sel_oob = 1'b0;
    end
`endif

    // Next-state logic: grant in IDLE, ISS always advances to DONE, DONE always returns to IDLE
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (grant_ld)
                    state_nxt = LD_ISS;
                else if (grant_cpu)
                    state_nxt = CPU_ISS;
                else
                    state_nxt = IDLE;
            end
            CPU_ISS:  state_nxt = CPU_DONE;
            LD_ISS:   state_nxt = LD_DONE;
            CPU_DONE: state_nxt = IDLE;
            LD_DONE:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register; reset mid-access abandons the handshake but an issued write is already in the RAM
    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Starvation counter: counts loader wins while the CPU waits, cleared when the CPU wins or stops asking
    always_ff @(posedge clock) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!cpu_req || grant_cpu)
            starve_cnt <= '0;
        else if (grant_ld && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    // Capture the granted access so a requester dropping its request cannot disturb it
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_oob   <= 1'b0;
        end else if (grant_ld || grant_cpu) begin
            acc_we    <= sel_we;
            acc_addr  <= sel_addr[ADDR_W+1:2];
            acc_wdata <= sel_wdata;
            acc_oob   <= sel_oob;
        end
    end

    // RAM port is active only during ISS; rejected accesses never enable the RAM
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_iss) begin
            mem_en    = !acc_oob;
            mem_we    = acc_we && !acc_oob;
            mem_addr  = acc_addr;
            mem_wdata = acc_wdata;
        end
    end

    // Read data seen in DONE; rejected reads return zero
    always_comb begin
        rd_val = acc_oob ? 32'h0 : mem_rdata;
    end

    // Hold the last CPU read result for use after the stall releases
    always_ff @(posedge clock) begin
        if (!reset)
            cpu_rdata_q <= '0;
        else if (cpu_done && !acc_we)
            cpu_rdata_q <= rd_val;
    end

    // Hold the last loader read result
    always_ff @(posedge clock) begin
        if (!reset)
            ld_rdata_q <= '0;
        else if (ld_done && !acc_we)
            ld_rdata_q <= rd_val;
    end

    // Read data is forwarded in DONE so it is valid in the same cycle the stall drops / ack pulses
    always_comb begin
        cpu_rdata = (cpu_done && !acc_we) ? rd_val : cpu_rdata_q;
        ld_rdata  = (ld_done && !acc_we) ? rd_val : ld_rdata_q;
    end

    assign cpu_stall = cpu_req && !cpu_done;
    assign ld_ack    = ld_done;

`ifdef DMEM_ARB_BOUND_EN
    assign err = (cpu_done || ld_done) && acc_oob;
`else
    assign err = 1'b0;
`endif

endmodule
